des_cbc_sequencer: RTL
======================

# des_cbc_sequencer

Sequential CBC-mode controller for the DES datapath. Accepts a stream of 64-bit blocks over a valid/ready handshake and drives an external fixed-latency DES core with the chained input. Owns the IV/chaining register, encrypt/decrypt selection and message boundaries. Converts the combinational CBC encrypt/decrypt flow into a clocked, back-pressured block stream.

## Interface
- CORE_LAT, 0: cycles between a registered `core_in` and a valid `core_out`; 0 means a combinational core.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_load  in  1  load key, IV and mode; one-cycle pulse.
- cfg_key  in  [64:1]  DES key, sampled on `cfg_load`.
- cfg_iv  in  [64:1]  initial vector, sampled on `cfg_load`.
- cfg_decrypt  in  1  0 = CBC encrypt, 1 = CBC decrypt; sampled on `cfg_load`.
- cfg_err  out  1  one-cycle pulse when `cfg_load` arrives in WAIT or OUT.
- in_valid, in_ready  in/out  1  input handshake.
- in_data  in  [64:1]  plaintext (encrypt) or ciphertext (decrypt).
- in_last  in  1  marks the final block of a message.
- out_valid, out_ready  out/in  1  output handshake.
- out_data  out  [64:1]  result block.
- out_last  out  1  copy of `in_last` for this block.
- core_key  out  [64:1]  registered key to the DES core.
- core_in  out  [64:1]  registered core input.
- core_dec  out  1  core direction.
- core_out  in  [64:1]  DES core result.
- blk_count  out  [17:1]  blocks completed in the current message.

## Operation
- FSM states:
  - IDLE, the reset state. Stays here until the first `cfg_load`, which moves it to READY.
  - READY. On `cfg_load`, reloads config and stays in READY. On an input handshake, moves to WAIT.
  - WAIT. Loads a counter with CORE_LAT. Moves to OUT at the first edge where the counter is 0, capturing the result there.
  - OUT. Holds `out_valid` and `out_data` stable until `out_valid && out_ready`, then returns to READY.
- `in_ready` = (state == READY) && !cfg_load. `cfg_load` takes priority over a same-cycle input.
- Registers: `iv_reg`, `chain`, `key_reg`, `dec_reg`. `cfg_load` writes `chain <= cfg_iv` and clears `blk_count`.
- Encrypt path:
  - On accept: `core_in <= in_data ^ chain`.
  - On capture: `out_data <= core_out` and `chain <= core_out`.
- Decrypt path:
  - On accept: `core_in <= in_data` and `hold <= in_data`.
  - On capture: `out_data <= core_out ^ chain` and `chain <= hold`.
- Message end: on the output handshake of a block with `out_last = 1`, `chain <= iv_reg` and `blk_count <= 0`. Otherwise `blk_count` increments on each output handshake.
- `blk_count` wraps from 131071 to 0 without a flag.
- `cfg_load` in WAIT or OUT is ignored apart from the `cfg_err` pulse. The block in flight completes with the old configuration.
- Reset mid-operation discards the block in flight. The block returns to IDLE and requires a new `cfg_load`.
- All state, counters, `chain`, `iv_reg`, `key_reg`, `core_in`, `core_key` and `core_dec` reset to 0.

## Timing
- Reset values: `in_ready` 0, `out_valid` 0, `out_data` 0, `out_last` 0, `cfg_err` 0, `blk_count` 0, `core_*` outputs 0.
- Pipeline for an input accepted at edge N:
  - `core_in` is valid after edge N.
  - Result is captured at edge N+1+CORE_LAT.
  - `out_valid` is high from that edge onward.
- With `out_ready` held high:
  - The output handshake occurs at edge N+2+CORE_LAT.
  - `in_ready` is high in the following cycle.
  - Peak throughput is 1 block per CORE_LAT+3 cycles.
- `out_valid` never drops without a handshake. `out_data` and `out_last` are stable while `out_valid` is high.
- `cfg_err` is a single cycle, registered, asserted the edge after the offending `cfg_load`.

## Configuration
- `DES_CBC_BLKCNT_EN`:
  - Defined: the 17-bit `blk_count` counter is implemented as described.
  - Undefined: no counter logic is built, `blk_count` is tied to 0, and all other behaviour is unchanged.

## Test plan
- Single-block encrypt, CORE_LAT=0, key 133457799BBCDFF1, IV 0. Send `in_data` 0123456789ABCDEF with `in_last=1` → `out_data` 85E813540F0AB405, `out_last=1`, output 2 edges after accept, `chain` returns to 0.
- Single-block decrypt, same key and IV. Send 85E813540F0AB405 → `out_data` 0123456789ABCDEF.
- Four-block encrypt then decrypt round-trip, IV 133457799BBCDFF1, CORE_LAT=3.
  - Encrypt output matches the reference CBC model.
  - Feeding that output back in decrypt mode recovers the original plaintexts.
  - With `DES_CBC_BLKCNT_EN`, `blk_count` reads 1, 2, 3, then 0 after the last block.
- Back-pressure: hold `out_ready=0` for 10 cycles in OUT.
  - `out_data` is stable throughout.
  - `in_ready` stays 0.
  - The block completes with correct chaining once released.
- Two consecutive messages. The second message's first block equals the single-block case, proving `chain` reloaded `iv_reg` after `in_last`.
- Disruption:
  - `cfg_load` issued in WAIT → `cfg_err` pulses once and the current block's result is unchanged.
  - `rst` asserted in OUT → all outputs 0 next cycle and the FSM is in IDLE.
  - `cfg_load` and `in_valid` in the same cycle in READY → `in_ready` is 0 and the input is not consumed.

Source files
------------

// File: rtl/des_cbc_sequencer.sv
// CBC-mode sequencer that feeds an external fixed-latency DES core over a valid/ready stream.
// Optional block counter built when DES_CBC_BLKCNT_EN is defined; otherwise blk_count is 0.
module des_cbc_sequencer #(
    parameter int unsigned CORE_LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_load,
    input  logic [64:1] cfg_key,
    input  logic [64:1] cfg_iv,
    input  logic        cfg_decrypt,
    output logic        cfg_err,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [64:1] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [64:1] out_data,
    output logic        out_last,
    output logic [64:1] core_key,
    output logic [64:1] core_in,
    output logic        core_dec,
    input  logic [64:1] core_out,
    output logic [17:1] blk_count
);

    localparam int unsigned CntW = (CORE_LAT > 0) ? $clog2(CORE_LAT + 1) : 1;

    typedef enum logic [1:0] {StIdle, StReady, StWait, StOut} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   lat_q;
    logic [64:1]       key_q, iv_q, chain_q, hold_q, core_in_q, out_data_q;
    logic              dec_q, last_q, cfg_err_q;
    logic              accept, out_fire, capture, cfg_ok, cfg_bad;

    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign capture  = (state_q == StWait) && (lat_q == '0);
    assign cfg_ok   = cfg_load && ((state_q == StIdle) || (state_q == StReady));
    assign cfg_bad  = cfg_load && ((state_q == StWait) || (state_q == StOut));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cfg_load) state_d = StReady;
            StReady: if (accept) state_d = StWait;
            StWait:  if (lat_q == '0) state_d = StOut;
            StOut:   if (out_ready) state_d = StReady;
            default: state_d = StIdle;
        endcase
    end

    // A same-cycle cfg_load wins over an input handshake.
    always_comb begin
        in_ready  = (state_q == StReady) && !cfg_load;
        out_valid = (state_q == StOut);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_q      <= '0;
            key_q      <= '0;
            iv_q       <= '0;
            chain_q    <= '0;
            hold_q     <= '0;
            core_in_q  <= '0;
            out_data_q <= '0;
            dec_q      <= 1'b0;
            last_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            cfg_err_q <= cfg_bad;
            if (cfg_ok) begin
                key_q   <= cfg_key;
                iv_q    <= cfg_iv;
                chain_q <= cfg_iv;
                dec_q   <= cfg_decrypt;
            end
            if (accept) begin
                core_in_q <= dec_q ? in_data : (in_data ^ chain_q);
                hold_q    <= in_data;
                last_q    <= in_last;
                lat_q     <= CntW'(CORE_LAT);
            end else if ((state_q == StWait) && (lat_q != '0)) begin
                lat_q <= lat_q - CntW'(1);
            end
            if (capture) begin
                out_data_q <= dec_q ? (core_out ^ chain_q) : core_out;
                chain_q    <= dec_q ? hold_q : core_out;
            end
            // End of message: the next block chains from the configured IV again.
            if (out_fire && last_q) begin
                chain_q <= iv_q;
            end
        end
    end

`ifdef DES_CBC_BLKCNT_EN
    logic [17:1] blk_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || cfg_ok) begin
            blk_cnt_q <= '0;
        end else if (out_fire) begin
            blk_cnt_q <= last_q ? '0 : (blk_cnt_q + 17'd1);
        end
    end

    assign blk_count = blk_cnt_q;
`else
    assign blk_count = '0;
`endif

    assign cfg_err  = cfg_err_q;
    assign out_data = out_data_q;
    assign out_last = last_q;
    assign core_key = key_q;
    assign core_in  = core_in_q;
    assign core_dec = dec_q;

endmodule
